ifetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage. Owns the PC and drives a handshaked instruction-memory port that may take several cycles to respond. Handles branch/jump redirects from later stages and backpressure from decode through a one-entry output slot plus a one-entry skid buffer. Sits between the PC/IM datapath and the IF/ID boundary.

---
 rtl/ifetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ifetch_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC and drives a handshaked instruction-memory port.
// A one-entry output slot plus a one-entry skid buffer absorb decode
// backpressure. Branch/jump redirects flush everything fetched so far.
// Optional IFETCH_PERF_EN adds perf_fetched / perf_bubble counters.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble
`endif
);

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] RESET_WORD = RESET_PC[31:2];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [AW-1:0]   tgt;
    logic            sk_valid;
    logic [AW-1:0]   sk_pc;
    logic [DW-1:0]   sk_instr;

    logic            ack_c;
    logic            consume_c;
    logic [AW-1:0]   pc_inc_c;

    // Handshake qualifiers: ack only counts while a request is up.
    assign ack_c     = imem_ack && imem_req;
    assign consume_c = if_valid && id_ready;
    assign pc_inc_c  = pc + AW'(1);

    // The request address is the PC register itself, so it is stable
    // for as long as the request is held.
    assign imem_addr = pc;

    // Fetch sequencer: state, PC, slot and skid registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            pc       <= RESET_WORD;
            tgt      <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
            sk_valid <= 1'b0;
            sk_pc    <= '0;
            sk_instr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                end

                REQ: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        sk_valid <= 1'b0;
                        imem_req <= 1'b1;
                        if (ack_c) begin
                            // Response discarded; the new target is requested next.
                            pc    <= redirect_pc;
                            state <= REQ;
                        end else begin
                            // Request still in flight: keep its address, park the target.
                            tgt   <= redirect_pc;
                            state <= DROP;
                        end
                    end else if (ack_c) begin
                        pc <= pc_inc_c;
                        if (!if_valid || id_ready) begin
                            if_valid <= 1'b1;
                            if_pc    <= {pc, 2'b00};
                            if_instr <= imem_rdata;
                        end else begin
                            sk_valid <= 1'b1;
                            sk_pc    <= pc;
                            sk_instr <= imem_rdata;
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (consume_c) begin
                        if_valid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        sk_valid <= 1'b0;
                        pc       <= redirect_pc;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else if (id_ready && sk_valid) begin
                        // Slot drains to decode and is refilled from the skid.
                        if_valid <= 1'b1;
                        if_pc    <= {sk_pc, 2'b00};
                        if_instr <= sk_instr;
                        sk_valid <= 1'b0;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end

                DROP: begin
                    if_valid <= 1'b0;
                    if (redirect) begin
                        tgt <= redirect_pc;
                    end
                    if (ack_c) begin
                        pc    <= redirect ? redirect_pc : tgt;
                        state <= REQ;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    if_valid <= 1'b0;
                    sk_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    // Performance counters: responses loaded, and empty-slot cycles after IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_bubble  <= '0;
        end else begin
            if ((state == REQ) && ack_c && !redirect) begin
                perf_fetched <= perf_fetched + 32'(1);
            end
            if ((state != IDLE) && !if_valid) begin
                perf_bubble <= perf_bubble + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: directed scenarios with literal expectations
// plus a stream-level reference model checked every cycle.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic        id_ready;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
`endif

    int cmp_n = 0;
    int err_n = 0;

    ifetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_bubble (perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: acks once the request has been held for 'lat' cycles.
    int lat  = 0;
    int wcnt = 0;
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = {2'b00, imem_addr};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        cmp_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: the ordered stream of accepted fetches, the next
    // address that must be requested, and whether an in-flight request is stale.
    logic [29:0] q[$];
    int          since = 0;
    logic [29:0] want_addr = 30'hC00;
    bit          stale = 1'b0;
    bit          prev_wait = 1'b0;
    logic [29:0] prev_addr = '0;
    logic [31:0] fetched_n = '0;
    logic [31:0] bubble_n = '0;

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            chk("rst_req", 64'(imem_req), 64'd0);
            chk("rst_valid", 64'(if_valid), 64'd0);
            chk("rst_pc", 64'(if_pc), 64'd0);
            q.delete();
            since     = 0;
            want_addr = 30'hC00;
            stale     = 1'b0;
            prev_wait = 1'b0;
            fetched_n = '0;
            bubble_n  = '0;
        end else begin
            chk("m_req", 64'(imem_req), 64'((since > 0) && (q.size() < 2)));
            chk("m_valid", 64'(if_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("m_if_pc", 64'(if_pc), 64'({q[0], 2'b00}));
                chk("m_if_instr", 64'(if_instr), 64'({2'b00, q[0]}));
            end
            if (imem_req) begin
                if (prev_wait) chk("m_addr_held", 64'(imem_addr), 64'(prev_addr));
                else           chk("m_addr_new", 64'(imem_addr), 64'(want_addr));
            end
`ifdef IFETCH_PERF_EN
            chk("m_perf_fetched", 64'(perf_fetched), 64'(fetched_n));
            chk("m_perf_bubble", 64'(perf_bubble), 64'(bubble_n));
`endif
            if ((since > 0) && !if_valid) bubble_n = bubble_n + 1;
            if (redirect) begin
                q.delete();
                want_addr = redirect_pc;
                stale     = imem_req && !imem_ack;
            end else begin
                if (if_valid && id_ready && q.size() != 0) void'(q.pop_front());
                if (imem_req && imem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        q.push_back(imem_addr);
                        want_addr = imem_addr + 30'd1;
                        fetched_n = fetched_n + 1;
                    end
                end
            end
            prev_wait = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (since < 1000) since++;
        end
    end

    int          lat_tab[8] = '{0, 0, 1, 0, 2, 0, 0, 3};
    logic [47:0] rdy_pat    = 48'hF37B_E6FF_1DBF;

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1; lat = 0;
        repeat (3) @(negedge clk);

        // Reset release and zero-wait sequential fetch
        rst = 1'b1; #2;
        chk("t1_idle_req", 64'(imem_req), 64'd0);
        @(negedge clk); #2;
        chk("t1_addr0", 64'(imem_addr), 64'h0C00);
        chk("t1_req", 64'(imem_req), 64'd1);
        chk("t1_novalid", 64'(if_valid), 64'd0);
        @(negedge clk); #2;
        chk("t1_addr1", 64'(imem_addr), 64'h0C01);
        chk("t1_valid", 64'(if_valid), 64'd1);
        chk("t1_pc0", 64'(if_pc), 64'h3000);
        chk("t1_instr0", 64'(if_instr), 64'h0C00);
        @(negedge clk); id_ready = 1'b0; #2;
        chk("t1_addr2", 64'(imem_addr), 64'h0C02);
        chk("t1_pc1", 64'(if_pc), 64'h3004);
`ifdef IFETCH_PERF_EN
        chk("t1_perf_fetched", 64'(perf_fetched), 64'd2);
        chk("t1_perf_bubble", 64'(perf_bubble), 64'd1);
`endif

        // Backpressure: slot 0x3004, skid 0x3008, no request
        @(negedge clk); #2;
        chk("t2_hold_req", 64'(imem_req), 64'd0);
        chk("t2_hold_pc", 64'(if_pc), 64'h3004);
        @(negedge clk); #2;
        chk("t2_hold_req2", 64'(imem_req), 64'd0);
        chk("t2_hold_valid", 64'(if_valid), 64'd1);
        @(negedge clk); id_ready = 1'b1; #2;
        chk("t2_pc_last", 64'(if_pc), 64'h3004);
        @(negedge clk); #2;
        chk("t2_pc_skid", 64'(if_pc), 64'h3008);
        chk("t2_addr", 64'(imem_addr), 64'h0C03);
        chk("t2_req", 64'(imem_req), 64'd1);

        // Redirect to 0x40 on an ack cycle
        @(negedge clk); redirect = 1'b1; redirect_pc = 30'h10; #2;
        chk("t2_pc_next", 64'(if_pc), 64'h300C);
        chk("t3_ack", 64'(imem_ack), 64'd1);
        @(negedge clk); redirect = 1'b0; #2;
        chk("t3_flush", 64'(if_valid), 64'd0);
        chk("t3_addr", 64'(imem_addr), 64'h10);

        // Slow memory with two redirects while a request is in flight
        @(negedge clk); lat = 3; redirect = 1'b1; redirect_pc = 30'h20; #2;
        chk("t3_pc", 64'(if_pc), 64'h40);
        chk("t3_instr", 64'(if_instr), 64'h10);
        chk("t4_addr_w0", 64'(imem_addr), 64'h11);
        @(negedge clk); redirect_pc = 30'h24; #2;
        chk("t4_drop_valid", 64'(if_valid), 64'd0);
        chk("t4_addr_w1", 64'(imem_addr), 64'h11);
        @(negedge clk); redirect = 1'b0; #2;
        chk("t4_addr_w2", 64'(imem_addr), 64'h11);
        chk("t4_noack", 64'(imem_ack), 64'd0);
        @(negedge clk); #2;
        chk("t4_stale_ack", 64'(imem_ack), 64'd1);
        chk("t4_stale_valid", 64'(if_valid), 64'd0);
        @(negedge clk); lat = 0; #2;
        chk("t4_new_addr", 64'(imem_addr), 64'h24);
        chk("t4_no_stale", 64'(if_valid), 64'd0);
        @(negedge clk); lat = 3; #2;
        chk("t4_pc", 64'(if_pc), 64'h90);
        chk("t4_instr", 64'(if_instr), 64'h24);

        // Reset asserted mid-wait
        @(negedge clk); #2;
        chk("t5_req_before", 64'(imem_req), 64'd1);
        #1; rst = 1'b0; #1;
        chk("t5_req_async", 64'(imem_req), 64'd0);
        chk("t5_valid_async", 64'(if_valid), 64'd0);
        @(negedge clk); lat = 0;
        @(negedge clk); rst = 1'b1; #2;
        chk("t5_idle", 64'(imem_req), 64'd0);
        @(negedge clk); #2;
        chk("t5_restart", 64'(imem_addr), 64'h0C00);

        // PC wrap at the top of the address space
        @(negedge clk); redirect = 1'b1; redirect_pc = 30'h3FFF_FFFF; #2;
        chk("t6_pc0", 64'(if_pc), 64'h3000);
        @(negedge clk); redirect = 1'b0; #2;
        chk("t6_addr_top", 64'(imem_addr), 64'h3FFF_FFFF);
        @(negedge clk); #2;
        chk("t6_addr_wrap", 64'(imem_addr), 64'h0);
        chk("t6_pc_top", 64'(if_pc), 64'hFFFF_FFFC);
        @(negedge clk); #2;
        chk("t6_pc_wrap", 64'(if_pc), 64'h0);

        // Mixed backpressure / latency / redirect pattern (model-checked)
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            id_ready    = rdy_pat[i];
            lat         = lat_tab[i % 8];
            redirect    = (i == 10) || (i == 11) || (i == 27) || (i == 40);
            redirect_pc = 30'h100 + 30'(i * 4);
        end
        @(negedge clk);
        redirect = 1'b0; id_ready = 1'b1; lat = 0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
